control_sequencer: RTL
======================

# control_sequencer

Control sequencer for the 8-bit register datapath. It consumes the instruction register's byte, holds the program counter, and steps a six-T-state fetch/execute machine. Each T-state drives the bus-source select and load strobes that the A register, B register, instruction register, memory address register and output register sample on the next rising edge. It sits directly downstream of the instruction register and upstream of every load enable in the datapath.

## Interface
- PC_W, 4, program-counter width; memory depth is 2^PC_W
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes state and PC and forces all strobes to 0
- run  in  1  leaves IDLE when high; ignored in any other state
- instr  in  8  instruction register output: opcode [7:4], operand [3:0]
- pc  out  PC_W  current program counter
- bus_sel  out  3  bus source: 0 none, 1 PC, 2 RAM, 3 IR operand, 4 A, 5 ALU
- mar_load  out  1  memory address register load
- ir_load  out  1  instruction register load
- a_load  out  1  A register load
- b_load  out  1  B register load
- out_load  out  1  output register load
- alu_sub  out  1  ALU subtract select; 0 = add
- tstate  out  3  state code: 0 IDLE, 1-6 T1-T6, 7 HALT
- halted  out  1  high in HALT

## Operation
- State and PC are registered. Strobes and bus_sel are decoded combinationally from state and instr (Moore on state, plus opcode in T4-T6).
- Any strobe not listed for a state is 0.
- Opcodes:
  - LDA = 0x0
  - ADD = 0x1
  - SUB = 0x2
  - OUT = 0xE
  - HLT = 0xF
  - all others are NOP
- IDLE: no strobes. run=1 moves to T1.
- T1: bus_sel=1, mar_load.
- T2: PC increments at the end of the cycle; no strobes.
- T3: bus_sel=2, ir_load.
- T4:
  - LDA/ADD/SUB: bus_sel=3, mar_load.
  - OUT: bus_sel=4, out_load.
  - HLT: no strobes; next state HALT.
  - NOP: no strobes.
- T5:
  - LDA: bus_sel=2, a_load.
  - ADD/SUB: bus_sel=2, b_load.
  - Others: no strobes.
- T6:
  - ADD: bus_sel=5, a_load.
  - SUB: bus_sel=5, alu_sub, a_load.
  - Others: no strobes.
- Transitions: T1→…→T6→T1, except T4 with HLT→HALT. No early exit for short instructions; every instruction takes exactly 6 cycles.
- HALT is sticky. Only rst_n low leaves it; run is ignored.
- PC wraps modulo 2^PC_W: with PC_W=4, 15 increments to 0.

## Timing
- Reset values, asserted immediately on rst_n low: state IDLE, tstate=0, pc=0, halted=0, bus_sel=0, all loads 0, alu_sub=0.
- Reset mid-instruction: the async clear takes effect in the same cycle. No strobe glitches past the reset edge. Restart requires run.
- run sampled high in IDLE: T1 is in the following cycle.
- Instruction latency: 6 clocks from T1 entry to the next T1.
- The first instruction's T1 starts 1 clock after run.
- instr is sampled only in T4-T6. The new IR value (loaded at the end of T3) is valid from T4.
- ena=0: no state or PC change; strobes and bus_sel forced to 0; tstate and pc hold. Resuming with ena=1 continues the same T-state.
- halted asserts in the cycle after the HLT T4.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams
  - the state enum (IDLE, T1-T6, HALT) with its 3-bit codes
  - the bus_sel encodings
- The datapath register modules use the same package for bus_sel.
- One sub-module: program_counter.
  - Ports: clk, rst_n, inc, pc.
  - Width PC_W, async clear, wrap-around.
  - Instantiated once, with inc = ena & (state==T2).
- The FSM next-state logic and the strobe decode live in control_sequencer itself.

## Test plan
- Reset then idle: rst_n low 2 cycles, release, run=0 for 5 cycles → tstate=0, pc=0, all strobes 0 throughout.
- LDA fetch/execute: run=1 one cycle, instr=0x09 driven from T4 → cycles 1-6 show:
  - T1: bus_sel=1, mar_load
  - T2: no strobes
  - T3: bus_sel=2, ir_load
  - T4: bus_sel=3, mar_load
  - T5: bus_sel=2, a_load
  - T6: nothing
  - pc=1 after T2; tstate returns to 1.
- SUB: instr=0x2A → T5 b_load with bus_sel=2; T6 bus_sel=5, alu_sub=1, a_load=1. ADD 0x1A gives the same T6 with alu_sub=0.
- HLT and stickiness: instr=0xF0 → tstate=7 and halted=1 the cycle after T4; 10 cycles with run=1 → no change; rst_n low → tstate=0, halted=0.
- PC wrap and ena freeze: 16 NOP (0x50) instructions → pc goes 15→0. ena=0 for 3 cycles in T5 → tstate stays 5, strobes 0; ena=1 resumes at T5.
- Reset mid-instruction: rst_n low asynchronously in T3 with pc=3 → same cycle pc=0, ir_load=0, tstate=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the 8-bit register datapath: opcodes, sequencer states,
// bus source codes and a small opcode classifier.
package ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_RAM  = 3'd2,
        BUS_IR   = 3'd3,
        BUS_A    = 3'd4,
        BUS_ALU  = 3'd5
    } bus_sel_t;

    typedef enum logic [2:0] {
        I_LDA,
        I_ADD,
        I_SUB,
        I_OUT,
        I_HLT,
        I_NOP
    } instr_class_t;

    // The operand nibble is a don't-care here; only the opcode picks the class.
    function automatic instr_class_t classify(input logic [7:0] instr);
        casez (instr)
            {OP_LDA, 4'b????}: classify = I_LDA;
            {OP_ADD, 4'b????}: classify = I_ADD;
            {OP_SUB, 4'b????}: classify = I_SUB;
            {OP_OUT, 4'b????}: classify = I_OUT;
            {OP_HLT, 4'b????}: classify = I_HLT;
            default:           classify = I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath registers.
interface control_sequencer_if #(parameter int PC_W = 4);

    logic            ena;
    logic            run;
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;
    logic [2:0]      bus_sel;
    logic            mar_load;
    logic            ir_load;
    logic            a_load;
    logic            b_load;
    logic            out_load;
    logic            alu_sub;
    logic [2:0]      tstate;
    logic            halted;

    modport master (
        input  ena, run, instr,
        output pc, bus_sel, mar_load, ir_load, a_load, b_load, out_load,
               alu_sub, tstate, halted
    );

    modport slave (
        output ena, run, instr,
        input  pc, bus_sel, mar_load, ir_load, a_load, b_load, out_load,
               alu_sub, tstate, halted
    );

endinterface

// File: rtl/program_counter.sv
// Program counter with async clear; wraps modulo 2^PC_W.
module program_counter #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Six-T-state fetch/execute sequencer: registered state and PC, strobes
// decoded combinationally from state (and opcode in T4-T6).
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_sequencer_if.master  bus
);

    state_t       state;
    instr_class_t cls;
    bus_sel_t     sel;
    logic         mar_load;
    logic         ir_load;
    logic         a_load;
    logic         b_load;
    logic         out_load;
    logic         alu_sub;

    assign cls = classify(bus.instr);

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.ena & (state == ST_T2)),
        .pc    (bus.pc)
    );

    // HALT only exits through rst_n; every instruction spends all six T-states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (bus.ena) begin
            case (state)
                ST_IDLE: if (bus.run) state <= ST_T1;
                ST_T1:   state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3:   state <= ST_T4;
                ST_T4:   state <= (cls == I_HLT) ? ST_HALT : ST_T5;
                ST_T5:   state <= ST_T6;
                ST_T6:   state <= ST_T1;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel      = BUS_NONE;
        mar_load = 1'b0;
        ir_load  = 1'b0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        out_load = 1'b0;
        alu_sub  = 1'b0;
        if (bus.ena) begin
            case (state)
                ST_T1: begin
                    sel      = BUS_PC;
                    mar_load = 1'b1;
                end
                ST_T3: begin
                    sel     = BUS_RAM;
                    ir_load = 1'b1;
                end
                ST_T4: begin
                    if (cls == I_LDA || cls == I_ADD || cls == I_SUB) begin
                        sel      = BUS_IR;
                        mar_load = 1'b1;
                    end else if (cls == I_OUT) begin
                        sel      = BUS_A;
                        out_load = 1'b1;
                    end
                end
                ST_T5: begin
                    if (cls == I_LDA) begin
                        sel    = BUS_RAM;
                        a_load = 1'b1;
                    end else if (cls == I_ADD || cls == I_SUB) begin
                        sel    = BUS_RAM;
                        b_load = 1'b1;
                    end
                end
                ST_T6: begin
                    if (cls == I_ADD || cls == I_SUB) begin
                        sel     = BUS_ALU;
                        a_load  = 1'b1;
                        alu_sub = (cls == I_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_sel  = sel;
    assign bus.mar_load = mar_load;
    assign bus.ir_load  = ir_load;
    assign bus.a_load   = a_load;
    assign bus.b_load   = b_load;
    assign bus.out_load = out_load;
    assign bus.alu_sub  = alu_sub;
    assign bus.tstate   = state;
    assign bus.halted   = (state == ST_HALT);

endmodule
